// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned LANE_W = 32;
  localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
  } stage_hdr_t;

  localparam stage_hdr_t HDR_EMPTY = '{valid: 1'b0, pc: 32'h0000_0000, instr: 32'h0000_0000, bd: 1'b0};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One pipeline slot: header plus NLANES payload lanes with clear > load > hold.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned NLANES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     clear,
  input  stage_hdr_t               hdr_in,
  input  logic [NLANES*LANE_W-1:0] data_in,
  output stage_hdr_t               hdr,
  output logic [NLANES*LANE_W-1:0] data
);

  localparam int unsigned DW = NLANES * LANE_W;

  stage_hdr_t    hdr_d, hdr_q;
  logic [DW-1:0] data_d, data_q;

  always_comb begin
    hdr_d  = hdr_q;
    data_d = data_q;
    if (clear) begin
      hdr_d  = HDR_EMPTY;
      data_d = {DW{1'b0}};
    end else if (load) begin
      hdr_d  = hdr_in;
      data_d = data_in;
    end else begin
      hdr_d  = hdr_q;
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q  <= HDR_EMPTY;
      data_q <= {DW{1'b0}};
    end else begin
      hdr_q  <= hdr_d;
      data_q <= data_d;
    end
  end

  assign hdr  = hdr_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready flow control, optional skid slot,
// flush / exception redirect and saturating stall/bubble counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned NLANES = 4,
  parameter bit          SKID   = 1'b1,
  parameter logic [31:0] EXC_PC = EXC_HANDLER_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     Req,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_bd,
  input  logic [NLANES*LANE_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_bd,
  output logic [NLANES*LANE_W-1:0] out_data,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              bubble_cnt
);

  localparam int unsigned DW = NLANES * LANE_W;

  stage_hdr_t    main_hdr, skid_hdr, beat_hdr, exc_hdr, main_hdr_in;
  logic [DW-1:0] main_data, skid_data, main_data_in;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          accept, drain;
  logic [31:0]   stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;

  assign beat_hdr = '{valid: 1'b1, pc: in_pc, instr: in_instr, bd: in_bd};
  assign exc_hdr  = '{valid: 1'b1, pc: EXC_PC, instr: 32'h0000_0000, bd: 1'b0};

  // With a skid slot in_ready comes straight from a flop, cutting the out_ready path.
  assign in_ready = SKID ? !skid_hdr.valid : (!main_hdr.valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = main_hdr.valid && out_ready;

  always_comb begin
    main_load    = 1'b0;
    main_clr     = 1'b0;
    main_hdr_in  = beat_hdr;
    main_data_in = in_data;
    skid_load    = 1'b0;
    skid_clr     = 1'b0;
    if (Req) begin
      main_load    = 1'b1;
      main_hdr_in  = exc_hdr;
      main_data_in = {DW{1'b0}};
      skid_clr     = 1'b1;
    end else if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (drain && skid_hdr.valid) begin
      main_load    = 1'b1;
      main_hdr_in  = skid_hdr;
      main_data_in = skid_data;
      if (accept) begin
        skid_load = 1'b1;
      end else begin
        skid_clr = 1'b1;
      end
    end else if (drain) begin
      if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end else if (accept && main_hdr.valid) begin
      skid_load = 1'b1;
    end else if (accept) begin
      main_load = 1'b1;
    end else begin
      main_load = 1'b0;
    end
  end

  pipe_slot #(.NLANES(NLANES)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clr),
    .hdr_in  (main_hdr_in),
    .data_in (main_data_in),
    .hdr     (main_hdr),
    .data    (main_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(.NLANES(NLANES)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clr),
      .hdr_in  (beat_hdr),
      .data_in (in_data),
      .hdr     (skid_hdr),
      .data    (skid_data)
    );
  end else begin : g_no_skid
    assign skid_hdr  = HDR_EMPTY;
    assign skid_data = {DW{1'b0}};
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_hdr.valid && !out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (out_ready && !main_hdr.valid) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // An empty main slot always holds zeroed fields, so downstream sees a nop.
  assign out_valid  = main_hdr.valid;
  assign out_pc     = main_hdr.pc;
  assign out_instr  = main_hdr.instr;
  assign out_bd     = main_hdr.bd;
  assign out_data   = main_data;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
